// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM encoding, request record and defaults for md_arbiter
package md_pkg;

    localparam int TIMEOUT_DEF = 15;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Accepted request as held by the arbiter while it is in flight.
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        owner;
    } md_req_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_MFLO);
    endfunction

    // Ops that make the unit go busy and must be waited on.
    function automatic logic op_uses_unit(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/md_rr_arb.sv
// rtl/md_rr_arb.sv - two-way round-robin grant with priority pointer
// Ports:
//   clk, reset   clock, asynchronous active-high reset (pointer -> requester 0)
//   req[1:0]     pending requests
//   advance      a grant was taken this cycle; pointer moves past the winner
//   grant[1:0]   one-hot (or zero) combinational grant
module md_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        // After any grant the other requester gets priority.
        if (advance) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/md_arbiter.sv
// rtl/md_arbiter.sv - two-requester front end sharing one mult/div unit
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   reqN_valid/op/a/b, reqN_ready     request handshake per requester (N = 0, 1)
//   reqN_done                         one-cycle completion pulse to the owner
//   rsp_hi, rsp_lo                    result captured when the response is formed
//   err                               sticky timeout flag
//   md_op, md_a, md_b                 one-cycle op issue to the unit (md_op 0 = no-op)
//   md_busy, md_hi, md_lo             unit status and HI/LO registers
module md_arbiter
    import md_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    output logic        req0_done,
    input  logic        req1_valid,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        err,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    md_req_t       cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_busy_q, seen_busy_d;
    logic          err_q, err_d;
    logic [31:0]   rsp_hi_q, rsp_hi_d;
    logic [31:0]   rsp_lo_q, rsp_lo_d;

    logic [1:0] grant;
    logic       idle;
    logic       accept;

    // Reset also gates the combinational grant so nothing is accepted while it is held.
    assign idle   = (state_q == ST_IDLE) && !reset;
    assign accept = idle && (req0_valid || req1_valid);

    md_rr_arb u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        err_d       = err_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_lo_d    = rsp_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_d.owner = grant[1];
                    cur_d.op    = grant[1] ? req1_op : req0_op;
                    cur_d.a     = grant[1] ? req1_a  : req0_a;
                    cur_d.b     = grant[1] ? req1_b  : req0_b;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d       = '0;
                seen_busy_d = 1'b0;
                state_d     = op_uses_unit(cur_q.op) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (md_busy) begin
                    seen_busy_d = 1'b1;
                end
                // A normal finish on the last allowed cycle wins over the timeout.
                if (seen_busy_q && !md_busy) begin
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_RESP) && (state_d == ST_RESP)) begin
            rsp_hi_d = md_hi;
            rsp_lo_d = md_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
            err_q       <= 1'b0;
            rsp_hi_q    <= '0;
            rsp_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
            err_q       <= err_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
        end
    end

    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];
    assign req0_done  = (state_q == ST_RESP) && !cur_q.owner;
    assign req1_done  = (state_q == ST_RESP) &&  cur_q.owner;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_lo     = rsp_lo_q;
    assign err        = err_q;

    // Illegal ops pass through the FSM without touching the unit.
    assign md_op = ((state_q == ST_ISSUE) && op_is_legal(cur_q.op)) ? cur_q.op : OP_NOP;
    assign md_a  = cur_q.a;
    assign md_b  = cur_q.b;

endmodule

// File: tb/tb_md_arbiter.sv
// tb/tb_md_arbiter.sv - self-checking bench for md_arbiter with transaction-level model
module tb_md_arbiter;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, req0_done, req1_done;
    logic [31:0] rsp_hi, rsp_lo;
    logic        err;
    logic [3:0]  md_op;
    logic [31:0] md_a, md_b;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;

    always #5 clk = ~clk;

    md_arbiter #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .err(err),
        .md_op(md_op), .md_a(md_a), .md_b(md_b),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;       // unit busy cycles; 0 = unit never responds
        int          lit_lat;   // literal accept->done latency, 0 = none
        int          lit_owner; // literal done owner, -1 = none
        bit          lit_hi_en;
        bit          lit_lo_en;
        logic [31:0] lit_hi;
        logic [31:0] lit_lo;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_valid = 1'b0;

    // Transaction-level model of the arbiter.
    bit          busy_m;
    int          ta, td, own, ptr_m;
    bit          tmo_m, err_m;
    txn_t        cur;
    logic [31:0] hi_m, lo_m, exp_hi, exp_lo;

    // Bench-side mult/div unit.
    int          ubusy, planned_lat;
    logic [31:0] uhi, ulo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        case (op)
            4'd1: return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            4'd2: return {32'b0, a} * {32'b0, b};
            4'd3: begin
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            4'd4: return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    function automatic txn_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
        txn_t t;
        t.op = op; t.a = a; t.b = b; t.lat = lat;
        t.lit_lat = 0; t.lit_owner = -1;
        t.lit_hi_en = 1'b0; t.lit_lo_en = 1'b0; t.lit_hi = '0; t.lit_lo = '0;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        logic [3:0] op;
        logic [31:0] b;
        op = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(9, 15));
        b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 50)) : $urandom;
        if (b == 32'd0 || b == 32'hFFFFFFFF) b = 32'd5;
        t = mk(op, $urandom, b, $urandom_range(1, 8));
        return t;
    endfunction

    task automatic model_reset();
        busy_m = 0; ptr_m = 0; err_m = 0; tmo_m = 0;
        hi_m = '0; lo_m = '0;
        ubusy = 0; planned_lat = 0; uhi = '0; ulo = '0;
        q0.delete();
        q1.delete();
    endtask

    task automatic model_accept(input int w);
        logic [63:0] r;
        if (w == 0) cur = q0.pop_front();
        else        cur = q1.pop_front();
        own = w; ta = cyc; busy_m = 1; ptr_m = 1 - w; planned_lat = cur.lat;
        if (cur.op >= 4'd1 && cur.op <= 4'd4) begin
            if (cur.lat >= 1) begin
                r = mdu_calc(cur.op, cur.a, cur.b);
                exp_hi = r[63:32]; exp_lo = r[31:0];
                hi_m = exp_hi; lo_m = exp_lo;
            end else begin
                exp_hi = hi_m; exp_lo = lo_m;
            end
            tmo_m = (cur.lat < 1) || (cur.lat > T - 1);
            td    = tmo_m ? ta + 1 + T + 1 : ta + 1 + cur.lat + 2;
        end else begin
            // Response captures the unit registers as they were before this op.
            exp_hi = hi_m; exp_lo = lo_m;
            tmo_m  = 0;
            td     = ta + 2;
            if (cur.op == 4'd5) hi_m = cur.a;
            if (cur.op == 4'd6) lo_m = cur.a;
        end
    endtask

    task automatic unit_step();
        logic [63:0] r;
        if (ubusy > 0) ubusy--;
        if (md_op >= 4'd1 && md_op <= 4'd4 && planned_lat > 0) begin
            r = mdu_calc(md_op, md_a, md_b);
            uhi = r[63:32]; ulo = r[31:0];
            ubusy = planned_lat;
        end else if (md_op == 4'd5) begin
            uhi = md_a;
        end else if (md_op == 4'd6) begin
            ulo = md_a;
        end
    endtask

    task automatic drive_inputs();
        if (q0.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
            req0_valid = 1'b1; req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b;
        end else begin
            req0_valid = 1'b0; req0_op = 4'($urandom); req0_a = $urandom; req0_b = $urandom;
        end
        if (q1.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
            req1_valid = 1'b1; req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b;
        end else begin
            req1_valid = 1'b0; req1_op = 4'($urandom); req1_a = $urandom; req1_b = $urandom;
        end
        md_busy = (ubusy > 0);
        md_hi   = uhi;
        md_lo   = ulo;
    endtask

    task automatic check_cycle();
        logic [1:0] v, exp_ready, exp_done, done_v;
        logic [3:0] exp_op;
        int win;
        v = {req1_valid, req0_valid};
        done_v = {req1_done, req0_done};
        win = -1;
        if (!busy_m && v != 2'b00) win = (v == 2'b11) ? ptr_m : (v[0] ? 0 : 1);
        exp_ready = 2'b00;
        if (win == 0) exp_ready = 2'b01;
        if (win == 1) exp_ready = 2'b10;
        exp_done = 2'b00;
        exp_op   = 4'd0;
        if (busy_m && cyc == td) begin
            exp_done[own] = 1'b1;
            if (tmo_m) err_m = 1'b1;
        end
        if (busy_m && cyc == ta + 1 && cur.op >= 4'd1 && cur.op <= 4'd8) exp_op = cur.op;

        chk("ready", {62'd0, req1_ready, req0_ready}, {62'd0, exp_ready});
        chk("done", {62'd0, done_v}, {62'd0, exp_done});
        chk("md_op", {60'd0, md_op}, {60'd0, exp_op});
        if (exp_op != 4'd0) begin
            chk("md_a", {32'd0, md_a}, {32'd0, cur.a});
            chk("md_b", {32'd0, md_b}, {32'd0, cur.b});
        end
        chk("err", {63'd0, err}, {63'd0, err_m});
        if (exp_done != 2'b00) begin
            chk("rsp_hi", {32'd0, rsp_hi}, {32'd0, exp_hi});
            chk("rsp_lo", {32'd0, rsp_lo}, {32'd0, exp_lo});
            if (cur.lit_lat > 0) chk("lit_latency", 64'(cyc - ta), 64'(cur.lit_lat));
            if (cur.lit_owner >= 0) chk("lit_owner", {62'd0, done_v}, 64'(1 << cur.lit_owner));
            if (cur.lit_hi_en) chk("lit_rsp_hi", {32'd0, rsp_hi}, {32'd0, cur.lit_hi});
            if (cur.lit_lo_en) chk("lit_rsp_lo", {32'd0, rsp_lo}, {32'd0, cur.lit_lo});
            busy_m = 0;
        end
        if (win >= 0) model_accept(win);
        unit_step();
    endtask

    task automatic do_cycle();
        @(negedge clk);
        cyc++;
        drive_inputs();
        #1;
        check_cycle();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; md_busy = 1'b0;
        model_reset();
        md_hi = '0; md_lo = '0;
        #1;
        chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        chk("rst_done", {62'd0, req1_done, req0_done}, 64'd0);
        chk("rst_md_op", {60'd0, md_op}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy_m) && n < budget) begin
            do_cycle();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int n;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        md_busy = 1'b0; md_hi = '0; md_lo = '0;
        apply_reset();

        // mult 3 * -4
        t = mk(4'd1, 32'd3, 32'hFFFFFFFC, 3);
        t.lit_lat = 6; t.lit_owner = 0;
        t.lit_hi_en = 1; t.lit_hi = 32'hFFFFFFFF; t.lit_lo_en = 1; t.lit_lo = 32'hFFFFFFF4;
        q0.push_back(t);
        run_until_idle(50);
        chk("err_after_mult", {63'd0, err}, 64'd0);

        // simultaneous requests after reset: req0 first
        apply_reset();
        t = mk(4'd2, 32'd2, 32'd3, 2);
        t.lit_owner = 0; t.lit_lo_en = 1; t.lit_lo = 32'd6;
        q0.push_back(t);
        t = mk(4'd4, 32'd7, 32'd2, 4);
        t.lit_owner = 1; t.lit_hi_en = 1; t.lit_hi = 32'd1; t.lit_lo_en = 1; t.lit_lo = 32'd3;
        q1.push_back(t);
        run_until_idle(60);

        // mthi then mfhi on req1
        t = mk(4'd5, 32'h1234, 32'd0, 1);
        t.lit_lat = 2; t.lit_owner = 1;
        q1.push_back(t);
        t = mk(4'd7, 32'd0, 32'd0, 1);
        t.lit_lat = 2; t.lit_owner = 1; t.lit_hi_en = 1; t.lit_hi = 32'h00001234;
        q1.push_back(t);
        run_until_idle(40);

        // illegal op
        t = mk(4'd9, 32'hDEAD, 32'hBEEF, 1);
        t.lit_lat = 2; t.lit_owner = 0;
        q0.push_back(t);
        run_until_idle(20);

        // reset in the middle of a div wait
        t = mk(4'd3, 32'd100, 32'd7, 10);
        q0.push_back(t);
        n = 0;
        while (!(busy_m && cyc >= ta + 4) && n < 30) begin
            do_cycle();
            n++;
        end
        if (n >= 30) chk("reach_wait_timeout", 64'd1, 64'd0);
        apply_reset();
        repeat (6) do_cycle();
        t = mk(4'd3, 32'hFFFFFF9C, 32'd7, 2);
        t.lit_lat = 5; t.lit_owner = 0;
        t.lit_hi_en = 1; t.lit_hi = 32'hFFFFFFFE; t.lit_lo_en = 1; t.lit_lo = 32'hFFFFFFF2;
        q0.push_back(t);
        run_until_idle(30);

        // randomized traffic from both requesters with valid dropping
        rand_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0) q0.push_back(rand_txn());
            else                           q1.push_back(rand_txn());
        end
        run_until_idle(6000);
        rand_valid = 1'b0;

        // unit never busy: timeout, sticky err
        apply_reset();
        t = mk(4'd1, 32'd5, 32'd6, 0);
        t.lit_lat = T + 2; t.lit_owner = 0;
        q0.push_back(t);
        run_until_idle(60);
        repeat (20) do_cycle();
        chk("err_sticky", {63'd0, err}, 64'd1);
        apply_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
